// File: rtl/contador_regressivo_mod.sv
// rtl/contador_regressivo_mod.sv - synchronous modulo-N down counter with load, enable and cascadable borrow
//
// Purpose:
//   Counts MODULUS-1, MODULUS-2, ..., 0, MODULUS-1, ... while enabled.
//   Supports synchronous preset to MODULUS-1 and a clamped parallel load.
//   Stages chain into multi-digit countdown timers by feeding borrow_out
//   of one stage into the enable of the next, more significant stage.
//
// Parameters:
//   MODULUS     number of states (2 .. 2**WIDTH), default 13
//   WIDTH       counter width in bits, default 4
//
// Ports:
//   clock       in   rising-edge clock for all state
//   reset       in   synchronous, active-high, highest priority; counter <- 0
//   preset      in   synchronous; counter <- MODULUS-1
//   load        in   synchronous; counter <- load_value, clamped to MODULUS-1
//   load_value  in   parallel load data (WIDTH bits)
//   enable      in   count enable; decrements once per cycle when no command
//   counter     out  registered current count
//   zero        out  combinational; counter == 0
//   borrow_out  out  combinational; enable & zero & no reset/preset/load
//   wrapped     out  registered; one-cycle pulse after a 0 -> MODULUS-1 wrap

module contador_regressivo_mod #(
    parameter int MODULUS = 13,
    parameter int WIDTH   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             preset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] counter,
    output logic             zero,
    output logic             borrow_out,
    output logic             wrapped
);

    // Terminal (reload) value of the count.
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    // Load data clamped into the legal range; out-of-range data loads TOP.
    logic [WIDTH-1:0] load_clamped;

    always_comb begin
        load_clamped = load_value;
        if (load_value > TOP) begin
            load_clamped = TOP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter <= '0;
            wrapped <= 1'b0;
        end else if (preset) begin
            counter <= TOP;
            wrapped <= 1'b0;
        end else if (load) begin
            counter <= load_clamped;
            wrapped <= 1'b0;
        end else if (enable) begin
            if (counter == '0) begin
                // Genuine wrap: the only path that raises wrapped.
                counter <= TOP;
                wrapped <= 1'b1;
            end else if (counter > TOP) begin
                // Recovery from an illegal state; not reported as a wrap.
                counter <= TOP;
                wrapped <= 1'b0;
            end else begin
                counter <= counter - WIDTH'(1);
                wrapped <= 1'b0;
            end
        end else begin
            wrapped <= 1'b0;
        end
    end

    assign zero = (counter == '0);

    // Any higher-priority command this cycle means this stage will not wrap,
    // so the next stage must not decrement either.
    assign borrow_out = enable & zero & ~reset & ~preset & ~load;

endmodule

// File: tb/tb_contador_regressivo_mod.sv
// tb/tb_contador_regressivo_mod.sv - self-checking bench for contador_regressivo_mod

module tb_contador_regressivo_mod;

    logic       clock = 1'b0;
    logic       reset, preset, load, enable;
    logic [3:0] load_value;
    logic [3:0] counter;
    logic       zero, borrow_out, wrapped;

    // Two-stage mod-10 cascade
    logic       c_reset, c_preset, c_enable;
    logic [3:0] lo_cnt, hi_cnt;
    logic       lo_zero, hi_zero, lo_borrow, hi_borrow, lo_wrap, hi_wrap;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    contador_regressivo_mod #(.MODULUS(13), .WIDTH(4)) dut (
        .clock(clock), .reset(reset), .preset(preset), .load(load),
        .load_value(load_value), .enable(enable), .counter(counter),
        .zero(zero), .borrow_out(borrow_out), .wrapped(wrapped)
    );

    contador_regressivo_mod #(.MODULUS(10), .WIDTH(4)) stage_lo (
        .clock(clock), .reset(c_reset), .preset(c_preset), .load(1'b0),
        .load_value(4'd0), .enable(c_enable), .counter(lo_cnt),
        .zero(lo_zero), .borrow_out(lo_borrow), .wrapped(lo_wrap)
    );

    contador_regressivo_mod #(.MODULUS(10), .WIDTH(4)) stage_hi (
        .clock(clock), .reset(c_reset), .preset(c_preset), .load(1'b0),
        .load_value(4'd0), .enable(lo_borrow), .counter(hi_cnt),
        .zero(hi_zero), .borrow_out(hi_borrow), .wrapped(hi_wrap)
    );

    typedef struct {
        logic       rst;
        logic       pre;
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       exp_zero_pre;
        logic       exp_borrow_pre;
        logic [3:0] exp_cnt;
        logic       exp_wrap;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic pre, input logic ld, input logic [3:0] lv,
                       input logic en, input logic zp, input logic bp,
                       input logic [3:0] cnt, input logic w);
        vec_t v;
        v.rst = rst; v.pre = pre; v.ld = ld; v.lv = lv; v.en = en;
        v.exp_zero_pre = zp; v.exp_borrow_pre = bp; v.exp_cnt = cnt; v.exp_wrap = w;
        vt.push_back(v);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int v, v_prev, hi_wraps;

        reset = 1'b1; preset = 1'b0; load = 1'b0; enable = 1'b0; load_value = 4'd0;
        c_reset = 1'b1; c_preset = 1'b0; c_enable = 1'b0;

        // rst pre ld lv en | zero_pre borrow_pre | cnt wrap
        add(1, 0, 0, 0,  0,  1, 0,  0,  0);          // reset from known zero
        add(0, 0, 0, 0,  1,  1, 1,  12, 1);          // first wrap right after reset
        for (int k = 11; k >= 0; k--)
            add(0, 0, 0, 0, 1,  0, 0,  4'(k), 0);    // 12 -> 0
        add(0, 0, 0, 0,  1,  1, 1,  12, 1);          // period of 13
        add(0, 0, 1, 15, 0,  0, 0,  12, 0);          // load clamp
        add(0, 0, 1, 5,  1,  0, 0,  5,  0);          // load beats enable
        add(0, 1, 1, 3,  0,  0, 0,  12, 0);          // preset beats load
        add(0, 0, 1, 7,  0,  0, 0,  7,  0);
        for (int k = 0; k < 5; k++)
            add(0, 0, 0, 0, 0,  0, 0,  7,  0);       // hold
        add(0, 0, 1, 0,  0,  0, 0,  0,  0);
        add(0, 0, 1, 4,  1,  1, 0,  4,  0);          // load gates borrow at zero
        add(0, 0, 1, 0,  0,  0, 0,  0,  0);
        add(0, 1, 0, 0,  1,  1, 0,  12, 0);          // preset gates borrow at zero
        add(1, 1, 1, 9,  1,  0, 0,  0,  0);          // reset beats everything
        add(1, 0, 0, 0,  1,  1, 0,  0,  0);          // reset cancels wrap

        tick();
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clock);
            reset = vt[i].rst; preset = vt[i].pre; load = vt[i].ld;
            load_value = vt[i].lv; enable = vt[i].en;
            #1;
            check($sformatf("v%0d zero_pre", i), int'(zero), int'(vt[i].exp_zero_pre));
            check($sformatf("v%0d borrow_pre", i), int'(borrow_out), int'(vt[i].exp_borrow_pre));
            tick();
            check($sformatf("v%0d counter", i), int'(counter), int'(vt[i].exp_cnt));
            check($sformatf("v%0d wrapped", i), int'(wrapped), int'(vt[i].exp_wrap));
            check($sformatf("v%0d zero", i), int'(zero), int'(vt[i].exp_cnt == 4'd0));
        end

        // Reset glitch between edges: no effect
        @(negedge clock);
        reset = 1'b0; preset = 1'b0; enable = 1'b0; load = 1'b1; load_value = 4'd1;
        tick();
        check("load_1", int'(counter), 1);
        @(negedge clock);
        load = 1'b0;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        check("glitch_counter", int'(counter), 1);

        // Reset raised mid-cycle and held across an edge
        @(negedge clock);
        enable = 1'b1;
        #1;
        check("pre_reset_counter", int'(counter), 1);
        #1 reset = 1'b1;
        tick();
        check("midreset_counter", int'(counter), 0);
        check("midreset_wrapped", int'(wrapped), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_reset_borrow", int'(borrow_out), 1);
        tick();
        check("post_reset_counter", int'(counter), 12);
        check("post_reset_wrapped", int'(wrapped), 1);
        @(negedge clock);
        enable = 1'b0;

        // Cascade: two mod-10 stages
        @(negedge clock);
        c_reset = 1'b0; c_preset = 1'b1;
        tick();
        check("casc_preset", int'(hi_cnt) * 10 + int'(lo_cnt), 99);
        @(negedge clock);
        c_preset = 1'b0; c_enable = 1'b1;
        v = 99;
        hi_wraps = 0;
        for (int k = 0; k < 100; k++) begin
            #1;
            check($sformatf("casc%0d lo_borrow", k), int'(lo_borrow), int'((v % 10) == 0));
            v_prev = v;
            v = (v == 0) ? 99 : v - 1;
            tick();
            check($sformatf("casc%0d value", k), int'(hi_cnt) * 10 + int'(lo_cnt), v);
            check($sformatf("casc%0d hi_wrap", k), int'(hi_wrap), int'(v_prev == 0));
            check($sformatf("casc%0d lo_wrap", k), int'(lo_wrap), int'((v_prev % 10) == 0));
            if (hi_wrap) hi_wraps++;
            @(negedge clock);
        end
        check("casc_hi_wrap_count", hi_wraps, 1);
        c_enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
